mc_mem_responder: RTL and testbench

//  Memory-side responder for the multi-cycle MIPS core's unified instr/data port.

---
 rtl/mc_mem_responder.sv | 195 +++++++++++++++++++
 tb/tb_mc_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_responder.sv
// ============================================================================
// mc_mem_responder
// ----------------------------------------------------------------------------
// Memory-side responder for the multi-cycle MIPS core's unified instruction /
// data port. One 32-bit word read or write is serviced per request through a
// req/ack handshake. WAIT_CYCLES wait states are inserted between acceptance
// and response to model slow memory. Misaligned or out-of-range accesses are
// answered with err=1 and have no side effect on the RAM.
//
// Parameters
//   DEPTH_LOG2   log2 of the number of 32-bit words (default 6 -> 64 words)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous reset, active-high
//   req     in   1   request valid, held stable with we/addr/wdata until ack
//   we      in   1   1 = write, 0 = read
//   addr    in   32  byte address, must be word aligned and in range
//   wdata   in   32  write data
//   rdata   out  32  read data (write data echoed on writes, 0 on error),
//                    valid in the ack cycle and held until the next response
//   ack     out  1   one-cycle response strobe
//   err     out  1   access error, meaningful only while ack=1
//   busy    out  1   high whenever the responder is not idle
// ============================================================================
module mc_mem_responder #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Wait-state counter preload. With WAIT_CYCLES==0 the WAIT state is
    // never entered, so the preload value is irrelevant there.
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        we_q,    we_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ack_q,   ack_d;
    logic        err_q,   err_d;

    // Word storage; contents deliberately survive reset.
    logic [31:0] mem [DEPTH];

    // ------------------------------------------------------------------------
    // Access operands. The access happens on the edge that enters RESP. With
    // zero wait states that is the acceptance edge itself, so the live inputs
    // are used; otherwise the values latched at acceptance are used, which
    // makes any input wiggling during WAIT harmless.
    // ------------------------------------------------------------------------
    logic                  acc_fire;
    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [31:0]           acc_addr_hi;
    logic                  acc_bad;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  mem_wr;

    always_comb begin
        acc_fire = 1'b0;
        if (state_q == ST_IDLE) begin
            acc_fire = req && (WAIT_CYCLES == 0);
        end else if (state_q == ST_WAIT) begin
            acc_fire = (cnt_q == 4'd0);
        end
    end

    assign acc_we    = (state_q == ST_IDLE) ? we    : we_q;
    assign acc_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;

    // Any address bit above the word index makes the access out of range.
    assign acc_addr_hi = acc_addr >> (DEPTH_LOG2 + 2);
    assign acc_bad     = (acc_addr[1:0] != 2'b00) || (acc_addr_hi != 32'd0);
    assign acc_idx     = acc_addr[DEPTH_LOG2+1:2];

    // Reset gating matters only on the zero-wait path, where the FSM sits in
    // IDLE during reset and a held req would otherwise still fire a write.
    assign mem_wr = acc_fire && !acc_bad && acc_we && !reset;

    // ------------------------------------------------------------------------
    // Next-state and registered-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Single response cycle; req is not looked at here, so a
                // held req is picked up again in the following IDLE cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (acc_fire) begin
            ack_d = 1'b1;
            err_d = acc_bad;
            if (acc_bad) begin
                rdata_d = 32'd0;
            end else if (acc_we) begin
                rdata_d = acc_wdata;
            end else begin
                rdata_d = mem[acc_idx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // RAM write port, no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mc_mem_responder.sv
// ============================================================================
// tb_mc_mem_responder
// ----------------------------------------------------------------------------
// Two responders side by side: g_dut[0] with two wait states, g_dut[1] with
// none. A word-array model computes the expected {err, rdata} of each access;
// expectations are queued when a request is issued and a negedge monitor pops
// and compares them whenever ack is seen. The access task checks latency,
// busy and timeouts. One line is printed per transaction.
// ============================================================================
module tb_mc_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s   [2];
    logic        req_s   [2];
    logic        we_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] wdata_s [2];
    logic [31:0] rdata_o [2];
    logic        ack_o   [2];
    logic        err_o   [2];
    logic        busy_o  [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            mc_mem_responder #(
                .DEPTH_LOG2 (6),
                .WAIT_CYCLES((gi == 0) ? 2 : 0)
            ) u_dut (
                .clk  (clk),
                .reset(rst_s[gi]),
                .req  (req_s[gi]),
                .we   (we_s[gi]),
                .addr (addr_s[gi]),
                .wdata(wdata_s[gi]),
                .rdata(rdata_o[gi]),
                .ack  (ack_o[gi]),
                .err  (err_o[gi]),
                .busy (busy_o[gi])
            );
        end
    endgenerate

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mm [2][64];       // expected memory contents
    logic [32:0] exp_q0[$];        // {err, rdata} per DUT
    logic [32:0] exp_q1[$];
    logic [31:0] last_rd [2];
    bit          in_resp [2];      // previous access ended with req still high

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%08h expected 0x%08h", name, d, act, exp);
        end
    endtask

    // Reference behaviour: 64 words, byte addresses, anything not a multiple
    // of 4 or at/after byte 256 is an error with no effect.
    task automatic model(input int d, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, output logic [32:0] e);
        logic [5:0] idx;
        idx = a[7:2];
        if ((a % 4) != 0 || a >= 32'd256) begin
            e = {1'b1, 32'h0};
        end else if (w) begin
            mm[d][idx] = wd;
            e = {1'b0, wd};
        end else begin
            e = {1'b0, mm[d][idx]};
        end
    endtask

    // Monitor: sampled just after the falling edge.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (rst_s[d]) begin
                    last_rd[d] = 32'd0;
                end else if (ack_o[d] === 1'b1) begin
                    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack dut%0d: got ack=1 expected no response", d);
                    end else begin
                        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check("rdata", d, rdata_o[d], e[31:0]);
                        check("err", d, {31'd0, err_o[d]}, {31'd0, e[32]});
                        last_rd[d] = e[31:0];
                        $display("dut%0d resp: rdata=0x%08h err=%0d (exp 0x%08h err=%0d)",
                                 d, rdata_o[d], err_o[d], e[31:0], e[32]);
                    end
                end else begin
                    check("ack", d, {31'd0, ack_o[d]}, 32'd0);
                    check("rdata_hold", d, rdata_o[d], last_rd[d]);
                    check("err_idle", d, {31'd0, err_o[d]}, 32'd0);
                end
            end
        end
    end

    // One access, started and finished at a falling edge. With hold=1 req
    // stays high into the next access (back-to-back). scramble wiggles the
    // inputs while the access is in flight.
    task automatic access(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input bit hold, input bit scramble, output int ack_cyc);
        logic [32:0] e;
        bit          got;
        int          n;
        bit          from_resp;
        from_resp = in_resp[d];
        if (!from_resp) check("busy_idle", d, {31'd0, busy_o[d]}, 32'd0);
        model(d, w, a, wd, e);
        if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        $display("dut%0d req: we=%0d addr=0x%08h wdata=0x%08h", d, w, a, wd);
        we_s[d] = w; addr_s[d] = a; wdata_s[d] = wd; req_s[d] = 1'b1;
        if (from_resp) @(posedge clk);     // RESP -> IDLE, req ignored
        @(posedge clk);                    // acceptance edge
        got = 0; n = 0; ack_cyc = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack_o[d] === 1'b1) begin
                got = 1; n = i; ack_cyc = cyc;
            end else begin
                check("busy_wait", d, {31'd0, busy_o[d]}, 32'd1);
                if (scramble) begin
                    addr_s[d] = $urandom; wdata_s[d] = $urandom; we_s[d] = 1'($urandom);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout dut%0d: got no ack expected ack after %0d cycles", d, wait_of(d));
        end else if (n != wait_of(d)) begin
            errors++;
            $display("FAIL latency dut%0d: got %0d expected %0d", d, n, wait_of(d));
        end
        if (got) check("busy_resp", d, {31'd0, busy_o[d]}, 32'd1);
        in_resp[d] = hold;
        if (!hold) begin
            req_s[d] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic release_hold(input int d);
        if (in_resp[d]) begin
            req_s[d] = 1'b0;
            @(negedge clk);
            in_resp[d] = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          c0, c1, c2, r;
        logic [31:0] a, old10;
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; req_s[d] = 0; we_s[d] = 0; addr_s[d] = 0; wdata_s[d] = 0;
            last_rd[d] = 0; in_resp[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) rst_s[d] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_rdata", d, rdata_o[d], 32'd0);
            check("rst_ack", d, {31'd0, ack_o[d]}, 32'd0);
            check("rst_err", d, {31'd0, err_o[d]}, 32'd0);
            check("rst_busy", d, {31'd0, busy_o[d]}, 32'd0);
        end

        // Known RAM contents
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) access(d, 1, 32'(i * 4), $urandom, 0, 0, c0);

        // Write/read, two wait states
        access(0, 1, 32'h0C, 32'hDEADBEEF, 0, 0, c0);
        access(0, 0, 32'h0C, 32'h0, 0, 0, c0);
        // Zero wait states
        access(1, 1, 32'h04, 32'h12345678, 0, 0, c0);
        access(1, 0, 32'h04, 32'h0, 0, 0, c0);

        // Error responses
        for (int d = 0; d < 2; d++) begin
            access(d, 1, 32'h6, 32'hFFFFFFFF, 0, 0, c0);
            access(d, 0, 32'h4, 32'h0, 0, 0, c0);
            access(d, 0, 32'h100, 32'h0, 0, 0, c0);
            access(d, 1, 32'h8000_0010, 32'hA5A5A5A5, 0, 0, c0);
            access(d, 0, 32'h10, 32'h0, 0, 0, c0);
        end

        // Back-to-back with req held high
        for (int d = 0; d < 2; d++) begin
            access(d, 0, 32'h00, 32'h0, 1, 0, c0);
            access(d, 0, 32'h04, 32'h0, 1, 0, c1);
            access(d, 0, 32'h08, 32'h0, 0, 0, c2);
            check("b2b_space1", d, 32'(c1 - c0), 32'(wait_of(d) + 2));
            check("b2b_space2", d, 32'(c2 - c1), 32'(wait_of(d) + 2));
        end

        // Inputs wiggling during WAIT
        access(0, 1, 32'h20, 32'hCAFEF00D, 0, 1, c0);
        access(0, 0, 32'h20, 32'h0, 0, 1, c0);

        // Reset during WAIT of a write to 0x10: no ack, old data kept
        old10 = mm[0][4];
        $display("dut0 req: we=1 addr=0x00000010 wdata=0x0BADC0DE (reset mid-wait)");
        we_s[0] = 1; addr_s[0] = 32'h10; wdata_s[0] = 32'h0BADC0DE; req_s[0] = 1;
        @(posedge clk);
        @(negedge clk);
        rst_s[0] = 1'b1; req_s[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_ack", 0, {31'd0, ack_o[0]}, 32'd0);
        end
        rst_s[0] = 1'b0;
        @(negedge clk);
        check("rst_mid_rdata", 0, rdata_o[0], 32'd0);
        check("rst_mid_busy", 0, {31'd0, busy_o[0]}, 32'd0);
        access(0, 0, 32'h10, 32'h0, 0, 0, c0);
        check("rst_mid_model", 0, mm[0][4], old10);

        // Randomized traffic
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 120; k++) begin
                r = $urandom_range(0, 9);
                if (r == 0)      a = ($urandom & 32'hFC) | 32'($urandom_range(1, 3));
                else if (r == 1) a = 32'h100 + 32'($urandom_range(0, 4000) * 4);
                else             a = 32'($urandom_range(0, 63) * 4);
                access(d, 1'($urandom), a, $urandom, ($urandom_range(0, 3) == 0),
                       (d == 0) && ($urandom_range(0, 2) == 0), c0);
            end
            release_hold(d);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d/%0d outstanding expected 0",
                     exp_q0.size(), exp_q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
